// File: rtl/uart_tx_buffered_if.sv
// Byte write port of the buffered UART transmitter: producer drives data/enable,
// transmitter answers with ready.
interface uart_tx_buffered_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic [PAYLOAD_BITS-1:0] wr_data;
  logic                    wr_en;
  logic                    wr_ready;

  modport master (output wr_data, output wr_en, input wr_ready);
  modport slave  (input wr_data, input wr_en, output wr_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: registered write stage, small FIFO, and a frame FSM
// that serialises N data bits (LSB first) with M stop bits onto uart_txd.
module uart_tx_buffered #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  uart_tx_buffered_if.slave          wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                       busy,
  output logic                       uart_txd
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int STOP_CYCLES    = STOP_BITS * CYCLES_PER_BIT;
  localparam int CYC_W          = $clog2(STOP_CYCLES);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int LVL_W          = PTR_W + 1;

  localparam logic [CYC_W-1:0] BIT_END  = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [CYC_W-1:0] STOP_END = CYC_W'(STOP_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [LVL_W-1:0] DEPTH    = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state;
  logic [CYC_W-1:0]        cyc_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [PAYLOAD_BITS-1:0] shift;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [LVL_W-1:0]        count;

  logic                    vld_p0;
  logic [PAYLOAD_BITS-1:0] data_p0;

  logic                    accept;
  logic                    avail;
  logic                    stop_last;
  logic                    pop;
  logic                    take_fifo;
  logic                    take_p0;
  logic                    push;
  logic                    shift_en;
  logic                    idle_next;
  logic [LVL_W-1:0]        count_next;
  logic [PAYLOAD_BITS-1:0] pop_data;

  // The staged byte is always newer than anything in the FIFO, so it is only
  // handed straight to the shifter when the FIFO is empty.
  assign accept     = wr.wr_en && wr.wr_ready;
  assign avail      = (count != '0) || vld_p0;
  assign stop_last  = (state == STOP) && (cyc_cnt == STOP_END);
  assign pop        = avail && ((state == IDLE) || stop_last);
  assign take_fifo  = pop && (count != '0);
  assign take_p0    = pop && (count == '0);
  assign push       = vld_p0 && !take_p0;
  assign count_next = count + LVL_W'(push) - LVL_W'(take_fifo);
  assign idle_next  = !pop && ((state == IDLE) || stop_last);
  assign pop_data   = take_fifo ? mem[rd_ptr] : data_p0;
  assign shift_en   = (cyc_cnt == BIT_END) &&
                      ((state == START) || ((state == DATA) && (bit_cnt != LAST_BIT)));
  assign fifo_level = count;

  // Stage p0: registered write, then FIFO storage and shift register (no reset on data)
  always_ff @(posedge clk) begin
    if (accept) data_p0 <= wr.wr_data;
    if (push)   mem[wr_ptr] <= data_p0;
    if (pop)           shift <= pop_data;
    else if (shift_en) shift <= shift >> 1;
  end

  // Ready accounts for the staged byte too, so a push always finds a free slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0      <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      wr.wr_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      vld_p0      <= accept;
      count       <= count_next;
      if (push)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (take_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      wr.wr_ready <= (count_next + LVL_W'(accept)) < DEPTH;
      busy        <= !idle_next || (count_next != '0);
    end
  end

  // Frame FSM: uart_txd is driven only from here
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            cyc_cnt  <= '0;
            uart_txd <= 1'b0;
          end
        end
        START: begin
          if (cyc_cnt == BIT_END) begin
            state    <= DATA;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            uart_txd <= shift[0];
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        DATA: begin
          if (cyc_cnt == BIT_END) begin
            cyc_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state    <= STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              uart_txd <= shift[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        STOP: begin
          if (cyc_cnt == STOP_END) begin
            cyc_cnt <= '0;
            if (pop) begin
              state    <= START;
              uart_txd <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
